// File: rtl/bsg_manycore_edge_pkg.sv
// Shared definitions for the manycore edge memory responder: request/reply opcodes
// and responder FSM state encodings.
package bsg_manycore_edge_pkg;

  typedef enum logic [1:0] {
    e_edge_store = 2'b00,
    e_edge_load  = 2'b01,
    e_edge_rsvd  = 2'b10,
    e_edge_reply = 2'b11
  } bsg_manycore_edge_op_e;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StReply = 2'd2;

endpackage

// File: rtl/bsg_manycore_edge_mem_ram.sv
// Single-port synchronous RAM, one-cycle read latency, contents not reset.
module bsg_manycore_edge_mem_ram #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 1024,
  parameter int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] data_q;

  assign data_o = data_q;

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) mem_q[addr_i] <= data_i;
    if (v_i & ~w_i) data_q <= mem_q[addr_i];
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO; ready_o is derived only from occupancy.
module bsg_two_fifo #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         cnt_q;
  logic               enq, deq;

  assign ready_o = (cnt_q != 2'd2);
  assign v_o     = (cnt_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_edge_mem_responder.sv
// Edge memory endpoint: executes stores/loads from an array edge link against a local RAM
// and returns load replies on the same link.
module bsg_manycore_edge_mem_responder
  import bsg_manycore_edge_pkg::*;
#(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 32,
  parameter int unsigned x_cord_width_p  = 2,
  parameter int unsigned y_cord_width_p  = 2,
  parameter int unsigned els_p           = 1024,
  parameter int unsigned packet_width_lp =
    2 + addr_width_p + data_width_p + y_cord_width_p + x_cord_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [packet_width_lp-1:0] link_data_i,
  input  logic                       link_v_i,
  output logic                       link_ready_o,
  output logic [packet_width_lp-1:0] link_data_o,
  output logic                       link_v_o,
  input  logic                       link_ready_i,
  output logic [15:0]                err_cnt_o,
  output logic                       idle_o
);

  localparam int unsigned lg_els_lp = $clog2(els_p);
  localparam int unsigned y_lsb_lp  = x_cord_width_p;
  localparam int unsigned d_lsb_lp  = y_lsb_lp + y_cord_width_p;
  localparam int unsigned a_lsb_lp  = d_lsb_lp + data_width_p;

  logic [packet_width_lp-1:0] fifo_data;
  logic                       fifo_v, fifo_yumi;

  bsg_two_fifo #(
    .width_p (packet_width_lp)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (link_ready_o),
    .data_i  (link_data_i),
    .v_i     (link_v_i),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (fifo_yumi)
  );

  bsg_manycore_edge_op_e      req_op;
  logic [addr_width_p-1:0]    req_addr;
  logic [data_width_p-1:0]    req_data;
  logic [y_cord_width_p-1:0]  req_y;
  logic [x_cord_width_p-1:0]  req_x;
  logic                       req_in_range;

  assign req_op       = bsg_manycore_edge_op_e'(fifo_data[packet_width_lp-1 -: 2]);
  assign req_addr     = fifo_data[a_lsb_lp +: addr_width_p];
  assign req_data     = fifo_data[d_lsb_lp +: data_width_p];
  assign req_y        = fifo_data[y_lsb_lp +: y_cord_width_p];
  assign req_x        = fifo_data[0 +: x_cord_width_p];
  assign req_in_range = ((req_addr >> lg_els_lp) == '0);

  logic                    ram_v, ram_w;
  logic [data_width_p-1:0] ram_rdata;

  bsg_manycore_edge_mem_ram #(
    .width_p (data_width_p),
    .els_p   (els_p)
  ) u_ram (
    .clk_i  (clk_i),
    .v_i    (ram_v),
    .w_i    (ram_w),
    .addr_i (req_addr[lg_els_lp-1:0]),
    .data_i (req_data),
    .data_o (ram_rdata)
  );

  logic [1:0]                 state_q, state_d;
  logic [addr_width_p-1:0]    addr_q, addr_d;
  logic [y_cord_width_p-1:0]  y_q, y_d;
  logic [x_cord_width_p-1:0]  x_q, x_d;
  logic                       in_range_q, in_range_d;
  logic [packet_width_lp-1:0] reply_q, reply_d;
  logic [15:0]                err_cnt_q, err_cnt_d;
  logic                       err_inc;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    y_d        = y_q;
    x_d        = x_q;
    in_range_d = in_range_q;
    reply_d    = reply_q;
    fifo_yumi  = 1'b0;
    ram_v      = 1'b0;
    ram_w      = 1'b0;
    err_inc    = 1'b0;
    case (state_q)
      StIdle: begin
        if (fifo_v) begin
          fifo_yumi = 1'b1;
          case (req_op)
            e_edge_store: begin
              if (req_in_range) begin
                ram_v = 1'b1;
                ram_w = 1'b1;
              end else begin
                err_inc = 1'b1;
              end
            end
            e_edge_load: begin
              ram_v      = 1'b1;
              addr_d     = req_addr;
              y_d        = req_y;
              x_d        = req_x;
              in_range_d = req_in_range;
              state_d    = StRead;
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
      StRead: begin
        // Out-of-range loads still reply, with zero data
        reply_d = {e_edge_reply, addr_q, (in_range_q ? ram_rdata : '0), y_q, x_q};
        err_inc = ~in_range_q;
        state_d = StReply;
      end
      StReply: begin
        if (link_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_cnt_d = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      y_q        <= '0;
      x_q        <= '0;
      in_range_q <= 1'b0;
      reply_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      y_q        <= y_d;
      x_q        <= x_d;
      in_range_q <= in_range_d;
      reply_q    <= reply_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign link_v_o    = (state_q == StReply);
  assign link_data_o = reply_q;
  assign err_cnt_o   = err_cnt_q;
  assign idle_o      = ~fifo_v & (state_q == StIdle);

endmodule
